// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//   Initiator side of the APB bus. Turns a single-requester req/gnt command
//   port into APB SETUP/ACCESS transfers, one transfer outstanding at a time.
//   Handles PREADY wait states, PSLVERR, misaligned addresses (rejected
//   without touching the bus) and a stuck-slave timeout.
//
// Ports
//   HCLK, HRESETn      clock (rising edge) and synchronous active-low reset
//   req_i/we_i/addr_i/wdata_i  command, held by the requester until gnt_o
//   gnt_o              command accepted this cycle (combinational)
//   rvalid_o           one-cycle completion pulse
//   rdata_o, err_o     completion data/status, meaningful with rvalid_o
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE   APB request outputs
//   PRDATA/PREADY/PSLVERR              APB response inputs
// ---------------------------------------------------------------------------
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    MISALIGN = 2'd3
  } state_t;

  // The counter only ever needs to reach TIMEOUT_CYCLES-1: it holds the number
  // of stalled ACCESS cycles already seen, so the last allowed cycle is the one
  // in which it equals TIMEOUT_CYCLES-1.
  localparam int  CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit  TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          to_cnt_reg;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [31:0]               pwdata_reg;
  logic                      pwrite_reg;
  logic                      rvalid_reg;
  logic [31:0]               rdata_reg;
  logic                      err_reg;

  logic accept;      // command taken in IDLE
  logic done_ok;     // slave answered with PREADY
  logic done_abort;  // timeout or misalign: error completion with zero data

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_i) begin
          accept     = 1'b1;
          state_next = (addr_i[1:0] == 2'b00) ? SETUP : MISALIGN;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        // PREADY in the final allowed cycle still completes normally.
        if (PREADY) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
          done_abort = 1'b1;
          state_next = IDLE;
        end
      end
      MISALIGN: begin
        done_abort = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    gnt_o   = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    case (state_reg)
      IDLE:    gnt_o = req_i;
      SETUP:   PSEL  = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latched command, timeout counter and completion registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      to_cnt_reg <= '0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      pwrite_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= done_ok | done_abort;

      if (accept) begin
        paddr_reg  <= addr_i;
        pwdata_reg <= wdata_i;
        pwrite_reg <= we_i;
      end

      if (accept) begin
        to_cnt_reg <= '0;
      end else if (TO_EN && (state_reg == ACCESS) && !PREADY) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (done_ok) begin
        rdata_reg <= pwrite_reg ? 32'h0 : PRDATA;
        err_reg   <= PSLVERR;
      end else if (done_abort) begin
        rdata_reg <= 32'h0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign PADDR    = paddr_reg;
  assign PWDATA   = pwdata_reg;
  assign PWRITE   = pwrite_reg;
  assign rvalid_o = rvalid_reg;
  assign rdata_o  = rdata_reg;
  assign err_o    = err_reg;

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

  logic        HCLK;
  logic        HRESETn;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_req_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: expected completion data/status and completion cycle
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Slave model configuration for the transfer in flight
  int          cfg_wait  = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  int          acc_cnt   = 0;

  // Protocol observation
  logic [11:0] exp_paddr  = '0;
  logic        exp_pwrite = 1'b0;
  logic        psel_prev  = 1'b0;
  logic        pen_prev   = 1'b0;
  int          psel_rise  = -1;
  int          pen_rise   = -1;
  int          acc_run    = 0;
  int          acc_len    = 0;
  int          psel_count = 0;
  int          last_acc   = 0;

  // Slave: PREADY after cfg_wait stalled ACCESS cycles
  always @(negedge HCLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc_cnt == cfg_wait);
      PSLVERR = PREADY ? cfg_err : 1'b0;
      PRDATA  = cfg_rdata;
      acc_cnt = acc_cnt + 1;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      acc_cnt = 0;
    end
  end

  // Monitor: completions against the scoreboard, plus bus-level observations
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (rvalid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("[TB] txn done cyc=%0d rdata=0x%08h err=%0d (exp cyc=%0d rdata=0x%08h err=%0d)",
                   cyc, rdata_o, err_o, e.cyc, e.rdata, e.err);
          check("rdata", rdata_o, e.rdata);
          check("err", {31'd0, err_o}, {31'd0, e.err});
          check("rvalid_cycle", cyc, e.cyc);
        end
      end
      if (PSEL) begin
        psel_count++;
        if ((PADDR !== exp_paddr) || (PWRITE !== exp_pwrite))
          check("paddr_pwrite_stable", {19'd0, PWRITE, PADDR}, {19'd0, exp_pwrite, exp_paddr});
      end
      if (!PSEL && PENABLE) check("penable_without_psel", 32'd1, 32'd0);
    end
    if (PSEL && !psel_prev) psel_rise = cyc;
    if (PENABLE && !pen_prev) pen_rise = cyc;
    if (PENABLE) acc_run++;
    else if (pen_prev) begin
      acc_len = acc_run;
      acc_run = 0;
    end
    psel_prev = PSEL;
    pen_prev  = PENABLE;
  end

  // Present a command at a negedge, wait (bounded) for gnt, optionally queue
  // the hand-computed completion (lat = cycles from accept to rvalid_o).
  task automatic issue(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       input int wait_st, input logic [31:0] prd, input logic perr,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input bit push);
    bit got;
    got = 1'b0;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (gnt_o) begin
        got = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    check("gnt_seen", {31'd0, got}, 32'd1);
    last_acc  = cyc;
    cfg_wait  = wait_st;
    cfg_rdata = prd;
    cfg_err   = perr;
    if (addr[1:0] == 2'b00) begin
      exp_paddr  = addr;
      exp_pwrite = we;
    end
    if (push) sb.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + lat});
    $display("[TB] txn issue cyc=%0d we=%0d addr=0x%03h wdata=0x%08h", cyc, we, addr, wd);
    @(posedge HCLK);
    @(negedge HCLK);
    req_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge HCLK);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("completion_within_budget", {31'd0, done}, 32'd1);
    @(negedge HCLK);
    @(negedge HCLK);
  endtask

  initial begin
    int a1;
    int pc;
    bit seen;
    HRESETn = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge HCLK);

    // Reset state
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_paddr", {20'd0, PADDR}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // 1: zero-wait write
    issue(1'b1, 12'h008, 32'h0000_0064, 0, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 3, 1'b1);
    a1 = last_acc;
    wait_idle();
    check("t1_psel_c1", psel_rise, a1 + 1);
    check("t1_penable_c2", pen_rise, a1 + 2);
    check("t1_pwdata", PWDATA, 32'h0000_0064);

    // 2: read with 3 wait states
    issue(1'b0, 12'h000, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 6, 1'b1);
    wait_idle();
    check("t2_access_len", acc_len, 4);

    // 3: slave error, then back-to-back read granted in the rvalid cycle
    issue(1'b0, 12'h010, 32'h0, 1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 4, 1'b1);
    a1 = last_acc;
    issue(1'b0, 12'h014, 32'h0, 0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 3, 1'b1);
    check("t3_b2b_gnt_cycle", last_acc, a1 + 4);
    wait_idle();
    check("t3_b2b_setup_cycle", psel_rise, last_acc + 1);

    // 4a: stuck slave, timeout after exactly 16 ACCESS cycles
    issue(1'b0, 12'h020, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 18, 1'b1);
    wait_idle();
    check("t4_timeout_access_len", acc_len, 16);
    // 4b: PREADY on the 16th ACCESS cycle completes normally
    issue(1'b0, 12'h024, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 18, 1'b1);
    wait_idle();
    check("t4_ready_last_access_len", acc_len, 16);

    // 5: misaligned address, no bus activity
    pc = psel_count;
    issue(1'b1, 12'h006, 32'h5555_AAAA, 0, 32'h0, 1'b0, 32'h0, 1'b1, 2, 1'b1);
    wait_idle();
    check("t5_no_psel", psel_count, pc);

    // 6: reset in the middle of ACCESS
    issue(1'b0, 12'h030, 32'h0, 1000, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (PENABLE) begin
        seen = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    check("t6_in_access", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    check("t6_psel_low", {31'd0, PSEL}, 32'd0);
    check("t6_penable_low", {31'd0, PENABLE}, 32'd0);
    check("t6_no_rvalid", {31'd0, rvalid_o}, 32'd0);
    req_i = 1'b1;
    #1;
    check("t6_gnt_eq_req", {31'd0, gnt_o}, 32'd1);
    @(negedge HCLK);
    req_i = 1'b0;
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);

    // Recovery transfer after reset
    issue(1'b0, 12'h040, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 3, 1'b1);
    wait_idle();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
